// File: rtl/morse_tx.sv
// =============================================================================
// morse_tx -- Morse code transmitter / encoder
//
// Accepts one uppercase ASCII letter at a time over a valid/ready handshake.
// The block looks up the letter's 10-bit symbol code and keys it out as timed
// marks and spaces on key_out. The same code is presented on code_out so the
// seven-segment decoder can echo the letter being sent.
//
// Code format (shared with the decode path):
//   bits[1:0]       = 00
//   bits[2k+3:2k+2] = symbol k (k = 0..3): 01 = dot, 11 = dash, 00 = end
//   Symbols are sent from bits[3:2] upward. Sending stops at the first 00 pair
//   or after four symbols.
//
// Timing, in units of UNIT_CYCLES clocks:
//   dot mark = 1, dash mark = 3, gap between symbols = 1, gap after letter = 3
//
// Optional feature (compile-time macro MORSE_WORD_GAP_EN):
//   When defined, ASCII space (0x20) is accepted. It produces a 4-unit silent
//   WGAP phase, which together with the preceding letter's 3-unit gap gives
//   the 7-unit word gap, and it loads code_out with the blank code 10'b1.
//   When undefined, space is rejected like any other unsupported character.
//
// Parameters:
//   UNIT_CYCLES  clk cycles per Morse time unit (>= 1)
//   CNT_W        width of the phase duration down-counter
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   char_in     ASCII character, sampled only on accept
//   char_valid  char_in is valid
//   char_ready  block can accept a character this cycle (state IDLE)
//   key_out     Morse key, 1 = mark (tone / LED on)
//   busy        a letter or a trailing gap is in progress
//   code_out    symbol code of the current / last accepted letter
//   err         one-cycle pulse: an unsupported character was rejected
// =============================================================================
module morse_tx #(
    parameter int UNIT_CYCLES = 5000000,
    parameter int CNT_W       = $clog2(7 * UNIT_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        key_out,
    output logic        busy,
    output logic [9:0]  code_out,
    output logic        err
);

    // -------------------------------------------------------------------------
    // Phase reload values. The counter is loaded with (units * UNIT_CYCLES - 1)
    // on phase entry and the phase ends on the cycle it reads zero, so every
    // phase lasts exactly units * UNIT_CYCLES clocks.
    // -------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(UNIT_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] LGAP_LOAD = CNT_W'(3 * UNIT_CYCLES - 32'sd1);
`ifdef MORSE_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WGAP_LOAD = CNT_W'(4 * UNIT_CYCLES - 32'sd1);
`endif
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

    localparam logic [1:0] SYM_DASH = 2'b11;
    localparam logic [1:0] SYM_END  = 2'b00;

`ifdef MORSE_WORD_GAP_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MARK = 3'd1,
        GAP  = 3'd2,
        LGAP = 3'd3,
        WGAP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MARK = 3'd1,
        GAP  = 3'd2,
        LGAP = 3'd3
    } state_t;
`endif

    // -------------------------------------------------------------------------
    // International Morse alphabet A-Z in the shared 10-bit code format.
    // Anything that is not an uppercase letter maps to all-zero.
    // -------------------------------------------------------------------------
    function automatic logic [9:0] letter_code(input logic [7:0] c);
        logic [9:0] code;
        case (c)
            8'h41:   code = 10'b0000110100; // A .-
            8'h42:   code = 10'b0101011100; // B -...
            8'h43:   code = 10'b0111011100; // C -.-.
            8'h44:   code = 10'b0001011100; // D -..
            8'h45:   code = 10'b0000000100; // E .
            8'h46:   code = 10'b0111010100; // F ..-.
            8'h47:   code = 10'b0001111100; // G --.
            8'h48:   code = 10'b0101010100; // H ....
            8'h49:   code = 10'b0000010100; // I ..
            8'h4A:   code = 10'b1111110100; // J .---
            8'h4B:   code = 10'b0011011100; // K -.-
            8'h4C:   code = 10'b0101110100; // L .-..
            8'h4D:   code = 10'b0000111100; // M --
            8'h4E:   code = 10'b0000011100; // N -.
            8'h4F:   code = 10'b0011111100; // O ---
            8'h50:   code = 10'b0111110100; // P .--.
            8'h51:   code = 10'b1101111100; // Q --.-
            8'h52:   code = 10'b0001110100; // R .-.
            8'h53:   code = 10'b0001010100; // S ...
            8'h54:   code = 10'b0000001100; // T -
            8'h55:   code = 10'b0011010100; // U ..-
            8'h56:   code = 10'b1101010100; // V ...-
            8'h57:   code = 10'b0011110100; // W .--
            8'h58:   code = 10'b1101011100; // X -..-
            8'h59:   code = 10'b1111011100; // Y -.--
            8'h5A:   code = 10'b0101111100; // Z --..
            default: code = 10'b0000000000;
        endcase
        return code;
    endfunction

    // Mark length for one symbol pair: dash is 3 units, anything else a dot.
    function automatic logic [CNT_W-1:0] mark_load(input logic [1:0] sym);
        logic [CNT_W-1:0] load;
        if (sym == SYM_DASH) begin
            load = DASH_LOAD;
        end else begin
            load = DOT_LOAD;
        end
        return load;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [7:0]       sym_r;        // remaining symbols, current one in [1:0]
    logic [7:0]       sym_next_s;
    logic [9:0]       code_r;
    logic [9:0]       code_next_s;
    logic             err_r;
    logic             err_next_s;
    logic             key_r;
    logic             busy_r;
    logic             ready_r;
    logic             is_letter_s;
    logic [9:0]       lut_code_s;

    assign is_letter_s = (char_in >= 8'h41) && (char_in <= 8'h5A);
    assign lut_code_s  = letter_code(char_in);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, counter, symbol shift and code/err decisions.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        sym_next_s   = sym_r;
        code_next_s  = code_r;
        err_next_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (char_valid) begin
                    if (is_letter_s) begin
                        code_next_s  = lut_code_s;
                        sym_next_s   = lut_code_s[9:2];
                        cnt_next_s   = mark_load(lut_code_s[3:2]);
                        state_next_s = MARK;
`ifdef MORSE_WORD_GAP_EN
                    end else if (char_in == 8'h20) begin
                        code_next_s  = 10'b0000000001;
                        sym_next_s   = 8'h00;
                        cnt_next_s   = WGAP_LOAD;
                        state_next_s = WGAP;
`endif
                    end else begin
                        // Rejected: stay idle, leave code_out alone.
                        err_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MARK: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else if (sym_r[3:2] != SYM_END) begin
                    // Another symbol follows: drop the one just sent.
                    sym_next_s   = {2'b00, sym_r[7:2]};
                    cnt_next_s   = GAP_LOAD;
                    state_next_s = GAP;
                end else begin
                    cnt_next_s   = LGAP_LOAD;
                    state_next_s = LGAP;
                end
            end
            GAP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_next_s   = mark_load(sym_r[1:0]);
                    state_next_s = MARK;
                end
            end
            LGAP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
`ifdef MORSE_WORD_GAP_EN
            WGAP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
`endif
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
                sym_next_s   = 8'h00;
            end
        endcase
    end

    // Datapath and registered outputs, decoded from the next state so they
    // line up with state_r (key_out rises on the first cycle after accept).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            sym_r   <= 8'h00;
            code_r  <= 10'b0000000000;
            err_r   <= 1'b0;
            key_r   <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_next_s;
            sym_r   <= sym_next_s;
            code_r  <= code_next_s;
            err_r   <= err_next_s;
            key_r   <= (state_next_s == MARK);
            busy_r  <= (state_next_s != IDLE);
            ready_r <= (state_next_s == IDLE);
        end
    end

    assign char_ready = ready_r;
    assign key_out    = key_r;
    assign busy       = busy_r;
    assign code_out   = code_r;
    assign err        = err_r;

endmodule

// File: tb/tb_morse_tx.sv
module tb_morse_tx;

    localparam int U = 4;

    logic       clk;
    logic       rst;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic [9:0] code_out;
    logic       err;

    morse_tx #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .code_out   (code_out),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_code_r = 10'b0;

    // Reference alphabet as dot/dash strings.
    string morse_tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
        "....", "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-",
        ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    typedef struct {
        logic [7:0] ch;
        logic       exp_err;
        logic       chk_code;
        logic [9:0] code;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit supported(input logic [7:0] c);
`ifdef MORSE_WORD_GAP_EN
        if (c == 8'h20) return 1'b1;
`endif
        return (c >= 8'h41 && c <= 8'h5A);
    endfunction

    function automatic logic [9:0] model_code(input string s);
        logic [9:0] c;
        c = 10'b0;
        for (int k = 0; k < s.len(); k++) begin
            byte b;
            b = s[k];
            c = c | (((b == 8'h2D) ? 10'd3 : 10'd1) << (2 * k + 2));
        end
        return c;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (char_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, (n < 500)}, 32'd1);
    endtask

    // Send one character and compare every cycle against the model.
    task automatic run_char(input logic [7:0] ch, input logic exp_err,
                            input logic chk_code, input logic [9:0] code_lit);
        bit q[$];
        logic [9:0] ecode;
        wait_ready();
        char_in    = ch;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        if (exp_err) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_key", {31'd0, key_out}, 32'd0);
            chk("err_busy", {31'd0, busy}, 32'd0);
            chk("err_ready", {31'd0, char_ready}, 32'd1);
            chk("err_code", {22'd0, code_out}, {22'd0, exp_code_r});
            @(negedge clk);
            chk("err_clear", {31'd0, err}, 32'd0);
            chk("err_code2", {22'd0, code_out}, {22'd0, exp_code_r});
        end else begin
            if (ch == 8'h20) begin
                ecode = 10'b0000000001;
                for (int i = 0; i < 4 * U; i++) q.push_back(1'b0);
            end else begin
                string s;
                s = morse_tbl[int'(ch) - 32'h41];
                ecode = chk_code ? code_lit : model_code(s);
                for (int k = 0; k < s.len(); k++) begin
                    byte b;
                    int d;
                    b = s[k];
                    d = (b == 8'h2D) ? 3 * U : U;
                    for (int i = 0; i < d; i++) q.push_back(1'b1);
                    if (k < s.len() - 1)
                        for (int i = 0; i < U; i++) q.push_back(1'b0);
                end
                for (int i = 0; i < 3 * U; i++) q.push_back(1'b0);
            end
            exp_code_r = ecode;
            chk("code", {22'd0, code_out}, {22'd0, ecode});
            chk("no_err", {31'd0, err}, 32'd0);
            foreach (q[i]) begin
                chk("key", {31'd0, key_out}, {31'd0, q[i]});
                chk("busy", {31'd0, busy}, 32'd1);
                chk("not_ready", {31'd0, char_ready}, 32'd0);
                @(negedge clk);
            end
            chk("end_ready", {31'd0, char_ready}, 32'd1);
            chk("end_busy", {31'd0, busy}, 32'd0);
            chk("end_key", {31'd0, key_out}, 32'd0);
            chk("end_code", {22'd0, code_out}, {22'd0, ecode});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MORSE_WORD_GAP_EN
        logic space_err = 1'b0;
`else
        logic space_err = 1'b1;
`endif
        vecs[0]  = '{8'h45, 1'b0, 1'b1, 10'b0000000100}; // E
        vecs[1]  = '{8'h41, 1'b0, 1'b1, 10'b0000110100}; // A
        vecs[2]  = '{8'h31, 1'b1, 1'b0, 10'b0};          // '1'
        vecs[3]  = '{8'h54, 1'b0, 1'b1, 10'b0000001100}; // T
        vecs[4]  = '{8'h51, 1'b0, 1'b1, 10'b1101111100}; // Q
        vecs[5]  = '{8'h40, 1'b1, 1'b0, 10'b0};          // just below 'A'
        vecs[6]  = '{8'h42, 1'b0, 1'b1, 10'b0101011100}; // B
        vecs[7]  = '{8'h5B, 1'b1, 1'b0, 10'b0};          // just above 'Z'
        vecs[8]  = '{8'h5A, 1'b0, 1'b0, 10'b0};          // Z
        vecs[9]  = '{8'h61, 1'b1, 1'b0, 10'b0};          // lowercase a
        vecs[10] = '{8'h20, space_err, 1'b0, 10'b0};     // space
        vecs[11] = '{8'h4A, 1'b0, 1'b0, 10'b0};          // J, longest letter

        rst        = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_key", {31'd0, key_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, char_ready}, 32'd1);
        chk("rst_code", {22'd0, code_out}, 32'd0);

        for (int v = 0; v < 12; v++)
            run_char(vecs[v].ch, vecs[v].exp_err, vecs[v].chk_code, vecs[v].code);

        // Randomized characters, mostly letters.
        for (int r = 0; r < 24; r++) begin
            logic [7:0] ch;
            if ($urandom_range(0, 9) < 7) ch = 8'h41 + 8'($urandom_range(0, 25));
            else ch = 8'($urandom_range(0, 255));
            run_char(ch, !supported(ch), 1'b0, 10'b0);
        end

        // char_valid held high: 'T' then 'E' back to back.
        wait_ready();
        char_in    = 8'h54;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_in = 8'h45;
        for (int c = 1; c <= 29; c++) begin
            chk("b2b_key", {31'd0, key_out}, {31'd0, ((c <= 12) || (c >= 26))});
            chk("b2b_busy", {31'd0, busy}, {31'd0, (c != 25)});
            chk("b2b_ready", {31'd0, char_ready}, {31'd0, (c == 25)});
            if (c == 26) begin
                chk("b2b_code", {22'd0, code_out}, 32'b0000000100);
                char_valid = 1'b0;
            end
            @(negedge clk);
        end
        wait_ready();

        // Reset in the middle of a 'T' dash.
        char_in    = 8'h54;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_key", {31'd0, key_out}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_key", {31'd0, key_out}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_code", {22'd0, code_out}, 32'd0);
        chk("mrst_ready", {31'd0, char_ready}, 32'd1);

        // Reset wins over an accept on the same edge.
        run_char(8'h4B, 1'b0, 1'b0, 10'b0);
        rst        = 1'b1;
        char_in    = 8'h45;
        char_valid = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        char_valid = 1'b0;
        chk("prio_busy", {31'd0, busy}, 32'd0);
        chk("prio_code", {22'd0, code_out}, 32'd0);
        chk("prio_ready", {31'd0, char_ready}, 32'd1);
        @(negedge clk);
        chk("prio_key", {31'd0, key_out}, 32'd0);
        chk("prio_busy2", {31'd0, busy}, 32'd0);
        exp_code_r = 10'b0;

        run_char(8'h31, 1'b1, 1'b0, 10'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
